// File: rtl/ebus_pkg.sv
// Shared definitions for the registered EBUS driver mux / arbiter.
// Holds the default geometry and the owner-index width helper.
// It also names the standard driver channels, so that top level wires
// every channel to the same index.
package ebus_pkg;

  // Default geometry of the EBUS and its diagnostics.
  localparam int EBUS_NDRV    = 12;
  localparam int EBUS_W       = 36;
  localparam int EBUS_CW      = 8;
  localparam int EBUS_TIMEOUT = 64;

  // One EBUS data word at the default width.
  typedef logic [EBUS_W-1:0] ebus_word_t;

  // Width of an owner index for n channels.
  // This is never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Standard driver channels in priority order.
  // A lower index wins the bus.
  typedef enum logic [3:0] {
    CH_APR = 4'd0,
    CH_CON = 4'd1,
    CH_CRA = 4'd2,
    CH_CTL = 4'd3,
    CH_EDP = 4'd4,
    CH_IR  = 4'd5,
    CH_MBZ = 4'd6,
    CH_MTR = 4'd7,
    CH_PI  = 4'd8,
    CH_SCD = 4'd9,
    CH_SHM = 4'd10,
    CH_VMA = 4'd11
  } ebus_chan_e;

endpackage

// File: rtl/ebus_mux_arb_if.sv
// EBUS driver/bus bundle between the per-module drivers and the mux.
// Optional parity lanes are present only when EBUS_PARITY_EN is defined.
//
// Handshake: ebusValid qualifies ebusData and ebusOwner for exactly one
// cycle. There is no ready, because the EBUS is a broadcast bus: every
// consumer samples on the edge where ebusValid is high. A driver holds its
// drvDriving bit high for every cycle it wants the bus. Losing arbitration
// is not back-pressured; it only shows up in the diagnostics.
interface ebus_mux_arb_if
  import ebus_pkg::*;
#(
  parameter int NDRV = EBUS_NDRV,
  parameter int W    = EBUS_W
);
  localparam int OW = owner_w(NDRV);

  logic [NDRV-1:0]   drvDriving;
  logic [NDRV*W-1:0] drvData;
  logic [W-1:0]      ebusData;
  logic              ebusValid;
  logic [OW-1:0]     ebusOwner;
`ifdef EBUS_PARITY_EN
  logic [NDRV-1:0]   drvParity;
  logic              ebusParity;

  modport master (output drvDriving, drvData, drvParity,
                  input  ebusData, ebusValid, ebusOwner, ebusParity);
  modport slave  (input  drvDriving, drvData, drvParity,
                  output ebusData, ebusValid, ebusOwner, ebusParity);
`else
  modport master (output drvDriving, drvData,
                  input  ebusData, ebusValid, ebusOwner);
  modport slave  (input  drvDriving, drvData,
                  output ebusData, ebusValid, ebusOwner);
`endif

endinterface

// File: rtl/ebus_prio_sel.sv
// Combinational fixed-priority selector for the EBUS drivers.
// It produces the lowest-index requester, whether any channel requests,
// and whether two or more channels request in the same cycle.
module ebus_prio_sel
  import ebus_pkg::*;
#(
  parameter int NDRV = EBUS_NDRV,
  parameter int OW   = owner_w(NDRV)
) (
  input  logic [NDRV-1:0] req,
  output logic [OW-1:0]   sel_idx,
  output logic            any_valid,
  output logic            multi_valid
);

  // Scan from the top down, so the lowest asserted index is written last and wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (req[i]) sel_idx = OW'(i);
    end
  end

  // Any requester, and contention (two or more requesters by population count).
  always_comb begin
    any_valid   = |req;
    multi_valid = ($countones(req) > 1);
  end

endmodule

// File: rtl/ebus_mux_arb.sv
// Registered EBUS driver mux with contention and hold-too-long diagnostics.
// The selected data, valid flag and owner appear one cycle after sampling.
// Diagnostics are sticky until diagClear; a new event in the clear cycle wins.
// Optional feature macro: EBUS_PARITY_EN adds odd-parity lanes and a sticky
// parity error flag.
module ebus_mux_arb
  import ebus_pkg::*;
#(
  parameter int NDRV    = EBUS_NDRV,
  parameter int W       = EBUS_W,
  parameter int CW      = EBUS_CW,
  parameter int TIMEOUT = EBUS_TIMEOUT,
  localparam int OW     = owner_w(NDRV)
) (
  input  logic            clk,
  input  logic            CROBAR_N,
  ebus_mux_arb_if.slave   bus,
  input  logic            diagClear,
  output logic            conflict,
  output logic [NDRV-1:0] conflictMask,
  output logic [CW-1:0]   conflictCount,
  output logic            timeout,
  output logic [OW-1:0]   timeoutOwner
`ifdef EBUS_PARITY_EN
  ,
  output logic            parityErr
`endif
);

  // The hold counter counts 0..TIMEOUT and saturates at TIMEOUT.
  localparam int            HW       = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(TIMEOUT);
  localparam logic [HW-1:0] HOLD_PRE = HW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [OW-1:0] sel_idx;
  logic          sel_any;
  logic          sel_multi;
  logic [W-1:0]  sel_data;

  logic [W-1:0]  data_q;
  logic          valid_q;
  logic [OW-1:0] owner_q;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_next;
  logic          to_evt;

  ebus_prio_sel #(
    .NDRV (NDRV),
    .OW   (OW)
  ) u_prio_sel (
    .req         (bus.drvDriving),
    .sel_idx     (sel_idx),
    .any_valid   (sel_any),
    .multi_valid (sel_multi)
  );

  // Mux the winning channel's word onto the bus, or zero when nobody drives.
  always_comb begin
    sel_data = '0;
    if (sel_any) sel_data = bus.drvData[int'(sel_idx) * W +: W];
  end

  // Hold counter next state.
  // A new owner reloads the counter to 1 and always beats a pending timeout.
  // A repeat owner counts up to TIMEOUT and then sticks there.
  always_comb begin
    hold_next = '0;
    to_evt    = 1'b0;
    if (sel_any) begin
      if (valid_q && (owner_q == sel_idx)) begin
        if (hold_q != HOLD_MAX) begin
          hold_next = hold_q + 1'b1;
          to_evt    = (hold_q == HOLD_PRE);
        end else begin
          hold_next = hold_q;
        end
      end else begin
        hold_next = HW'(1);
      end
    end
  end

  // Registered data path and hold counter; reset drops the bus immediately.
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
      hold_q  <= '0;
    end else begin
      data_q  <= sel_data;
      valid_q <= sel_any;
      owner_q <= sel_any ? sel_idx : '0;
      hold_q  <= hold_next;
    end
  end

  assign bus.ebusData  = data_q;
  assign bus.ebusValid = valid_q;
  assign bus.ebusOwner = owner_q;

  // Sticky contention diagnostics; a conflict in the clear cycle survives it.
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      conflict      <= 1'b0;
      conflictMask  <= '0;
      conflictCount <= '0;
    end else begin
      if (sel_multi)      conflict <= 1'b1;
      else if (diagClear) conflict <= 1'b0;

      conflictMask <= (diagClear ? '0 : conflictMask) |
                      (sel_multi ? bus.drvDriving : '0);

      if (diagClear)
        conflictCount <= sel_multi ? CW'(1) : '0;
      else if (sel_multi && (conflictCount != CNT_MAX))
        conflictCount <= conflictCount + 1'b1;
    end
  end

  // Sticky timeout diagnostics.
  // The owner is latched only for the first timeout since the last clear.
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      timeout      <= 1'b0;
      timeoutOwner <= '0;
    end else begin
      if (to_evt)         timeout <= 1'b1;
      else if (diagClear) timeout <= 1'b0;

      if (to_evt && (!timeout || diagClear)) timeoutOwner <= sel_idx;
      else if (diagClear)                    timeoutOwner <= '0;
    end
  end

`ifdef EBUS_PARITY_EN
  logic sel_par;
  logic par_bad;
  logic par_q;

  // Odd parity of the selected lane. An idle bus carries zero data, so its
  // parity bit is 1.
  always_comb begin
    sel_par = 1'b1;
    par_bad = 1'b0;
    if (sel_any) begin
      sel_par = bus.drvParity[sel_idx];
      par_bad = ~(^{sel_data, sel_par});
    end
  end

  // Parity lane registered alongside the data; the error flag is sticky.
  always_ff @(posedge clk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      par_q     <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      par_q <= sel_par;
      if (par_bad)        parityErr <= 1'b1;
      else if (diagClear) parityErr <= 1'b0;
    end
  end

  assign bus.ebusParity = par_q;
`endif

endmodule

// File: tb/tb_ebus_mux_arb.sv
// Bench for ebus_mux_arb, built with CW=2 and TIMEOUT=64.
// Stimulus pushes timestamped expectations into exp_q. A monitor pops and
// compares them each cycle, and also when an async-reset probe fires.
module tb_ebus_mux_arb;
  import ebus_pkg::*;

  localparam int NDRV = 12;
  localparam int W    = 36;
  localparam int CW   = 2;
  localparam int TO   = 64;
  localparam int OW   = 4;

  localparam int S_DATA  = 0;
  localparam int S_VALID = 1;
  localparam int S_OWNER = 2;
  localparam int S_CONF  = 3;
  localparam int S_MASK  = 4;
  localparam int S_COUNT = 5;
  localparam int S_TO    = 6;
  localparam int S_TOWN  = 7;
  localparam int S_PERR  = 8;
  localparam int S_PAR   = 9;

  typedef struct {
    int           cyc;
    int           sig;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic probe_tgl = 1'b0;

  logic            clk = 1'b0;
  logic            CROBAR_N;
  logic            diagClear;
  logic            conflict;
  logic [NDRV-1:0] conflictMask;
  logic [CW-1:0]   conflictCount;
  logic            timeout;
  logic [OW-1:0]   timeoutOwner;
`ifdef EBUS_PARITY_EN
  logic            parityErr;
`endif

  logic [W-1:0] chan_val [NDRV];

  ebus_mux_arb_if #(.NDRV(NDRV), .W(W)) bus ();

  ebus_mux_arb #(
    .NDRV    (NDRV),
    .W       (W),
    .CW      (CW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .CROBAR_N      (CROBAR_N),
    .bus           (bus),
    .diagClear     (diagClear),
    .conflict      (conflict),
    .conflictMask  (conflictMask),
    .conflictCount (conflictCount),
    .timeout       (timeout),
    .timeoutOwner  (timeoutOwner)
`ifdef EBUS_PARITY_EN
    ,
    .parityErr     (parityErr)
`endif
  );

  // Clock and cycle counter.
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] actual(input int sig);
    case (sig)
      S_DATA:  return bus.ebusData;
      S_VALID: return W'(bus.ebusValid);
      S_OWNER: return W'(bus.ebusOwner);
      S_CONF:  return W'(conflict);
      S_MASK:  return W'(conflictMask);
      S_COUNT: return W'(conflictCount);
      S_TO:    return W'(timeout);
      S_TOWN:  return W'(timeoutOwner);
`ifdef EBUS_PARITY_EN
      S_PERR:  return W'(parityErr);
      S_PAR:   return W'(bus.ebusParity);
`endif
      default: return '1;
    endcase
  endfunction

  // Monitor: compare every expectation that is due now.
  initial forever begin
    @(posedge clk or probe_tgl);
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic [W-1:0] act;
      e   = exp_q.pop_front();
      act = actual(e.sig);
      n_cmp++;
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d actual=%h expected=%h", e.name, cyc, act, e.val);
      end
    end
  end

  // Expect a value on the cycle after the current negedge's inputs are sampled.
  task automatic push(input int sig, input logic [W-1:0] val, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.sig = sig; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  // Expect a value right now, without waiting for a clock edge.
  task automatic push_now(input int sig, input logic [W-1:0] val, input string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NDRV-1:0] drv, input logic clr);
    @(negedge clk);
    bus.drvDriving = drv;
    diagClear      = clr;
  endtask

  task automatic push_all_zero(input string tag);
    push(S_DATA, '0, {tag, "_data"});
    push(S_VALID, '0, {tag, "_valid"});
    push(S_OWNER, '0, {tag, "_owner"});
    push(S_CONF, '0, {tag, "_conflict"});
    push(S_MASK, '0, {tag, "_mask"});
    push(S_COUNT, '0, {tag, "_count"});
    push(S_TO, '0, {tag, "_timeout"});
    push(S_TOWN, '0, {tag, "_towner"});
  endtask

  // Directed stimulus.
  initial begin
    chan_val[0]  = 36'h0_1234_5678;
    chan_val[1]  = 36'h1_0000_0001;
    chan_val[2]  = 36'o123456701234;
    chan_val[3]  = 36'h3_3333_3333;
    chan_val[4]  = 36'h4_4444_4444;
    chan_val[5]  = 36'h5_5A5A_5A5A;
    chan_val[6]  = 36'h6_0606_0606;
    chan_val[7]  = 36'h7_7777_7777;
    chan_val[8]  = 36'h8_0000_0008;
    chan_val[9]  = 36'h9_9999_9999;
    chan_val[10] = 36'hA_AAAA_AAAA;
    chan_val[11] = 36'hB_0B0B_0B0B;
    for (int i = 0; i < NDRV; i++) begin
      bus.drvData[i*W +: W] = chan_val[i];
`ifdef EBUS_PARITY_EN
      bus.drvParity[i] = ~^chan_val[i];
`endif
    end
    CROBAR_N       = 1'b0;
    diagClear      = 1'b0;
    bus.drvDriving = '0;

    // Everything reads zero while reset is held.
    step('0, 1'b0);
    push_all_zero("reset");
`ifdef EBUS_PARITY_EN
    push(S_PAR, '0, "reset_parity");
    push(S_PERR, '0, "reset_perr");
`endif
    @(negedge clk);
    CROBAR_N = 1'b1;
    step('0, 1'b0);
    push(S_VALID, '0, "idle_valid");
    push(S_DATA, '0, "idle_data");
`ifdef EBUS_PARITY_EN
    push(S_PAR, 36'h1, "idle_parity");
`endif

    // A single driver appears one cycle later; the bus then idles back to zero.
    step(12'h004, 1'b0);
    push(S_DATA, 36'o123456701234, "single_data");
    push(S_OWNER, 36'd2, "single_owner");
    push(S_VALID, 36'h1, "single_valid");
    push(S_CONF, '0, "single_conflict");
    step('0, 1'b0);
    push(S_VALID, '0, "single_idle_valid");
    push(S_DATA, '0, "single_idle_data");
    push(S_OWNER, '0, "single_idle_owner");

    // Contention between channels 3 and 7 for three cycles.
    for (int i = 1; i <= 3; i++) begin
      step(12'h088, 1'b0);
      if (i == 1) push(S_COUNT, 36'd1, "cont_count1");
    end
    push(S_OWNER, 36'd3, "cont_owner");
    push(S_DATA, 36'h3_3333_3333, "cont_data");
    push(S_CONF, 36'h1, "cont_conflict");
    push(S_MASK, 36'h088, "cont_mask");
    push(S_COUNT, 36'd3, "cont_count3");
    step('0, 1'b1);
    push(S_CONF, '0, "clr1_conflict");
    push(S_MASK, '0, "clr1_mask");
    push(S_COUNT, '0, "clr1_count");

    // Saturation of the 2-bit counter, then mask accumulation across patterns.
    for (int i = 1; i <= 10; i++) begin
      step(12'h300, 1'b0);
      if (i == 1) push(S_COUNT, 36'd1, "sat_count1");
      if (i == 3) push(S_COUNT, 36'd3, "sat_count3");
    end
    push(S_COUNT, 36'd3, "sat_count10");
    push(S_OWNER, 36'd8, "sat_owner");
    push(S_MASK, 36'h300, "sat_mask");
    step(12'h011, 1'b0);
    push(S_MASK, 36'h311, "accum_mask");
    push(S_OWNER, '0, "accum_owner");
    step('0, 1'b1);
    push(S_COUNT, '0, "clr2_count");
    push(S_CONF, '0, "clr2_conflict");
    push(S_MASK, '0, "clr2_mask");

    // A clear that coincides with a new conflict: the new event wins.
    step(12'h003, 1'b1);
    push(S_CONF, 36'h1, "coll_conflict");
    push(S_MASK, 36'h003, "coll_mask");
    push(S_COUNT, 36'd1, "coll_count");
    push(S_DATA, 36'h0_1234_5678, "coll_data");
    step('0, 1'b1);
    push(S_CONF, '0, "clr3_conflict");

    // Channel 5 holds the bus for exactly TIMEOUT cycles.
    for (int i = 1; i <= TO; i++) begin
      step(12'h020, 1'b0);
      if (i == TO - 1) push(S_TO, '0, "to_before");
    end
    push(S_TO, 36'h1, "to_flag");
    push(S_TOWN, 36'd5, "to_owner5");
    // The second timeout, on channel 6, must not move the captured owner.
    for (int i = 1; i <= 100; i++) step(12'h040, 1'b0);
    push(S_TO, 36'h1, "to_still");
    push(S_TOWN, 36'd5, "to_owner_kept");
    push(S_OWNER, 36'd6, "to_bus_owner6");
    // Clearing while the counter is saturated must not re-flag the timeout.
    step(12'h040, 1'b1);
    push(S_TO, '0, "to_clr");
    push(S_TOWN, '0, "to_clr_owner");
    repeat (5) step(12'h040, 1'b0);
    push(S_TO, '0, "to_no_reflag");

    // A timeout that coincides with a clear: the new event wins.
    step('0, 1'b0);
    for (int i = 1; i <= TO; i++) step(12'h200, (i == TO));
    push(S_TO, 36'h1, "to_coll_flag");
    push(S_TOWN, 36'd9, "to_coll_owner");
    step('0, 1'b1);
    push(S_TO, '0, "to_clr2");

    // An owner change exactly when the old owner would reach TIMEOUT.
    for (int i = 1; i < TO; i++) step(12'h100, 1'b0);
    step(12'h080, 1'b0);
    push(S_TO, '0, "chg_no_timeout");
    push(S_OWNER, 36'd7, "chg_owner");
    step('0, 1'b0);

`ifdef EBUS_PARITY_EN
    // Good parity on channel 10, then a flipped parity bit, then a clear.
    step(12'h400, 1'b0);
    push(S_PERR, '0, "par_good_err");
    push(S_PAR, 36'h1, "par_good_bit");
    @(negedge clk);
    bus.drvParity[10] = 1'b0;
    step(12'h400, 1'b0);
    push(S_PERR, 36'h1, "par_bad_err");
    push(S_PAR, '0, "par_bad_bit");
    step('0, 1'b0);
    bus.drvParity[10] = 1'b1;
    push(S_PERR, 36'h1, "par_sticky");
    push(S_PAR, 36'h1, "par_idle_bit");
    step('0, 1'b1);
    push(S_PERR, '0, "par_clr");
`endif

    // Async reset mid-transfer: the bus drops without an edge and keeps no history.
    step(12'h030, 1'b0);
    push(S_CONF, 36'h1, "pre_rst_conflict");
    step(12'h010, 1'b0);
    push(S_VALID, 36'h1, "pre_rst_valid");
    push(S_OWNER, 36'd4, "pre_rst_owner");
    @(posedge clk);
    #3;
    CROBAR_N = 1'b0;
    push_now(S_VALID, '0, "arst_valid");
    push_now(S_DATA, '0, "arst_data");
    push_now(S_OWNER, '0, "arst_owner");
    push_now(S_CONF, '0, "arst_conflict");
    push_now(S_MASK, '0, "arst_mask");
    push_now(S_COUNT, '0, "arst_count");
    probe_tgl = ~probe_tgl;
    #1;
    n_cmp++;
    if (bus.ebusValid !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_direct_valid actual=%b expected=0", bus.ebusValid);
    end
    n_cmp++;
    if (bus.ebusData !== '0) begin
      n_bad++;
      $display("FAIL arst_direct_data actual=%h expected=0", bus.ebusData);
    end
    n_cmp++;
    if (bus.ebusOwner !== '0) begin
      n_bad++;
      $display("FAIL arst_direct_owner actual=%h expected=0", bus.ebusOwner);
    end
    n_cmp++;
    if (conflict !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_direct_conflict actual=%b expected=0", conflict);
    end
    @(negedge clk);
    CROBAR_N = 1'b1;
    push(S_VALID, 36'h1, "post_rst_valid");
    push(S_OWNER, 36'd4, "post_rst_owner");
    push(S_DATA, 36'h4_4444_4444, "post_rst_data");
    push(S_CONF, '0, "post_rst_conflict");
    step('0, 1'b0);
    push(S_VALID, '0, "final_idle");

    // Drain, then report.
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s never compared (due cyc=%0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
